// File: rtl/rng_harvester.sv
// Von Neumann debiaser feeding a 4-deep nibble FIFO.
// A repetition-count health test latches a sticky fault and flushes.
module rng_harvester #(
  parameter int unsigned REP_LIMIT = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       raw_bit,
  input  logic       enable,
  input  logic       rd_req,
  output logic [3:0] rd_data,
  output logic       rd_valid,
  output logic [2:0] fifo_count,
  output logic       fault
);

  typedef enum logic {
    IDLE       = 1'b0,
    HAVE_FIRST = 1'b1
  } state_t;

  localparam logic [7:0] LIM = 8'(REP_LIMIT);

  state_t      r_state;
  state_t      w_state_n;
  logic        r_first;
  logic [2:0]  r_nib;
  logic [1:0]  r_bcnt;
  logic [3:0]  r_mem [4];
  logic [1:0]  r_wp;
  logic [1:0]  r_rp;
  logic [2:0]  r_cnt;
  logic [7:0]  r_rep;
  logic        r_prev;
  logic        r_fault;

  logic        w_latch;
  logic        w_emit;
  logic [7:0]  w_rep_n;
  logic        w_trip;
  logic        w_push;
  logic        w_pop;
  logic        w_push_ok;
  logic [3:0]  w_nib;

  always_comb begin
    w_rep_n = 8'd1;
    if (raw_bit == r_prev) begin
      w_rep_n = (r_rep == 8'hFF) ? r_rep : r_rep + 8'd1;
    end
  end

  assign w_trip = enable & ~r_fault & (w_rep_n >= LIM);

  always_comb begin
    w_state_n = r_state;
    w_latch   = 1'b0;
    w_emit    = 1'b0;
    if (!enable || r_fault || w_trip) begin
      w_state_n = IDLE;
    end else begin
      unique case (r_state)
        IDLE: begin
          w_state_n = HAVE_FIRST;
          w_latch   = 1'b1;
        end
        HAVE_FIRST: begin
          w_state_n = IDLE;
          w_emit    = (raw_bit != r_first);
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_first <= 1'b0;
    end else begin
      r_state <= w_state_n;
      if (w_latch) r_first <= raw_bit;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rep   <= '0;
      r_prev  <= 1'b0;
      r_fault <= 1'b0;
    end else if (enable) begin
      r_rep  <= w_rep_n;
      r_prev <= raw_bit;
      if (w_trip) r_fault <= 1'b1;
    end
  end

  // The emitted debiased bit is the first bit of the differing pair.
  assign w_nib  = {r_nib, r_first};
  assign w_push = w_emit & (r_bcnt == 2'd3);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_nib  <= '0;
      r_bcnt <= '0;
    end else if (w_trip) begin
      r_nib  <= '0;
      r_bcnt <= '0;
    end else if (w_emit) begin
      r_nib  <= w_nib[2:0];
      r_bcnt <= r_bcnt + 2'd1;
    end
  end

  assign w_pop     = rd_req & (r_cnt != 3'd0) & ~r_fault;
  assign w_push_ok = w_push & ((r_cnt != 3'd4) | w_pop);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
      for (int i = 0; i < 4; i++) r_mem[i] <= '0;
    end else if (w_trip) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push_ok) begin
        r_mem[r_wp] <= w_nib;
        r_wp        <= r_wp + 2'd1;
      end
      if (w_pop) r_rp <= r_rp + 2'd1;
      case ({w_push_ok, w_pop})
        2'b10:   r_cnt <= r_cnt + 3'd1;
        2'b01:   r_cnt <= r_cnt - 3'd1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  assign rd_valid   = (r_cnt != 3'd0) & ~r_fault;
  assign rd_data    = rd_valid ? r_mem[r_rp] : 4'h0;
  assign fifo_count = r_cnt;
  assign fault      = r_fault;

endmodule

// File: tb/tb_rng_harvester.sv
// Randomised and directed bench for rng_harvester
// against a queue-based reference model.
module tb_rng_harvester;

  localparam int LIM = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       raw_bit = 1'b0;
  logic       enable = 1'b0;
  logic       rd_req = 1'b0;
  logic [3:0] rd_data;
  logic       rd_valid;
  logic [2:0] fifo_count;
  logic       fault;

  int n_checks = 0;
  int n_fail = 0;

  rng_harvester #(.REP_LIMIT(LIM)) dut (
    .clk(clk),
    .reset(reset),
    .raw_bit(raw_bit),
    .enable(enable),
    .rd_req(rd_req),
    .rd_data(rd_data),
    .rd_valid(rd_valid),
    .fifo_count(fifo_count),
    .fault(fault)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  bit         pq[$];
  bit         bq[$];
  logic [3:0] fq[$];
  bit         m_prev;
  int         m_run;
  bit         m_fault;

  task automatic model_reset();
    pq.delete();
    bq.delete();
    fq.delete();
    m_prev  = 1'b0;
    m_run   = 0;
    m_fault = 1'b0;
  endtask

  // Advance the model by one clock using the inputs now applied.
  task automatic model_edge();
    bit pop;
    logic [3:0] nib;
    if (m_fault) return;
    pop = rd_req && (fq.size() > 0);
    if (enable) begin
      if (raw_bit == m_prev) m_run = (m_run < 255) ? m_run + 1 : 255;
      else m_run = 1;
      m_prev = raw_bit;
      if (m_run >= LIM) begin
        m_fault = 1'b1;
        fq.delete();
        bq.delete();
        pq.delete();
        return;
      end
      pq.push_back(raw_bit);
      if (pq.size() == 2) begin
        if (pq[0] != pq[1]) bq.push_back(pq[0]);
        pq.delete();
      end
    end else begin
      pq.delete();
    end
    if (pop) void'(fq.pop_front());
    if (bq.size() == 4) begin
      nib = {bq[0], bq[1], bq[2], bq[3]};
      bq.delete();
      if (fq.size() < 4) fq.push_back(nib);
    end
  endtask

  task automatic compare();
    logic       ev;
    logic [2:0] ec;
    logic [3:0] ed;
    ev = (fq.size() != 0);
    ec = 3'(fq.size());
    ed = ev ? fq[0] : 4'h0;
    n_checks++;
    if ({rd_valid, fifo_count, rd_data, fault} !== {ev, ec, ed, m_fault}) begin
      n_fail++;
      $display("FAIL cycle_cmp t=%0t got v=%b cnt=%0d d=%h f=%b want v=%b cnt=%0d d=%h f=%b",
               $time, rd_valid, fifo_count, rd_data, fault, ev, ec, ed, m_fault);
    end
  endtask

  task automatic lit(input string name, input int got, input int want);
    n_checks++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    compare();
  endtask

  task automatic samp(input bit b, input bit rq);
    enable  = 1'b1;
    raw_bit = b;
    rd_req  = rq;
    step();
    rd_req  = 1'b0;
  endtask

  task automatic send_bit(input bit b, input bit rq);
    samp(b, 1'b0);
    samp(~b, rq);
  endtask

  task automatic send_nib(input logic [3:0] n, input bit rq);
    for (int i = 3; i >= 0; i--) send_bit(n[i], (i == 0) ? rq : 1'b0);
  endtask

  task automatic idle_cyc();
    enable = 1'b0;
    rd_req = 1'b0;
    step();
  endtask

  task automatic pop_one();
    enable = 1'b0;
    rd_req = 1'b1;
    step();
    rd_req = 1'b0;
  endtask

  task automatic do_reset();
    enable = 1'b0;
    rd_req = 1'b0;
    reset  = 1'b0;
    model_reset();
    #3;
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    int pct;
    int flt_cyc;
    model_reset();
    #3;
    lit("reset_valid", rd_valid, 0);
    lit("reset_count", fifo_count, 0);
    lit("reset_fault", fault, 0);
    @(negedge clk);
    reset = 1'b1;

    // Single nibble 1011 from 10 01 10 10
    samp(1, 0); samp(0, 0); samp(0, 0); samp(1, 0);
    samp(1, 0); samp(0, 0); samp(1, 0);
    lit("nib_not_yet", fifo_count, 0);
    samp(0, 0);
    lit("nib_valid", rd_valid, 1);
    lit("nib_count", fifo_count, 1);
    lit("nib_data", rd_data, 4'hB);

    // Equal pairs discarded, then nibble 0 and a pop
    do_reset();
    samp(1, 0); samp(1, 0); samp(0, 0); samp(0, 0);
    for (int i = 0; i < 4; i++) send_bit(0, 0);
    lit("zero_count", fifo_count, 1);
    lit("zero_data", rd_data, 0);
    pop_one();
    lit("zero_pop_count", fifo_count, 0);
    lit("zero_pop_valid", rd_valid, 0);
    pop_one();
    lit("empty_pop_count", fifo_count, 0);

    // Full FIFO: drop on overflow, then push with pop
    do_reset();
    send_nib(4'hA, 0); send_nib(4'hB, 0);
    send_nib(4'hC, 0); send_nib(4'hD, 0);
    lit("full_count", fifo_count, 4);
    send_nib(4'hE, 0);
    lit("drop_count", fifo_count, 4);
    lit("drop_head", rd_data, 4'hA);
    send_nib(4'hF, 1);
    lit("pp_count", fifo_count, 4);
    lit("pp_head", rd_data, 4'hB);
    pop_one();
    lit("rd_c", rd_data, 4'hC);
    pop_one();
    lit("rd_d", rd_data, 4'hD);
    pop_one();
    lit("rd_f", rd_data, 4'hF);
    pop_one();
    lit("rd_empty", rd_valid, 0);

    // Repetition fault with two nibbles queued
    do_reset();
    send_nib(4'h5, 0); send_nib(4'h5, 0);
    for (int i = 0; i < 7; i++) samp(1, 0);
    lit("pre_fault", fault, 0);
    lit("pre_fault_cnt", fifo_count, 2);
    samp(1, 0);
    lit("fault_set", fault, 1);
    lit("fault_cnt", fifo_count, 0);
    lit("fault_valid", rd_valid, 0);
    for (int i = 0; i < 16; i++) samp(i[0], i[1]);
    lit("fault_nopush", fifo_count, 0);
    lit("fault_sticky", fault, 1);

    // Asynchronous reset mid-pair with three nibbles queued
    do_reset();
    send_nib(4'h3, 0); send_nib(4'h6, 0); send_nib(4'h9, 0);
    samp(0, 0);
    lit("pre_rst_cnt", fifo_count, 3);
    reset  = 1'b0;
    enable = 1'b0;
    model_reset();
    #2;
    lit("async_cnt", fifo_count, 0);
    lit("async_valid", rd_valid, 0);
    lit("async_data", rd_data, 0);
    lit("async_fault", fault, 0);
    @(negedge clk);
    reset = 1'b1;
    step();
    send_nib(4'h9, 0);
    lit("post_rst_data", rd_data, 4'h9);
    lit("post_rst_cnt", fifo_count, 1);

    // Enable gap inside a pair keeps partial nibble
    do_reset();
    send_bit(1, 0); send_bit(1, 0);
    samp(0, 0);
    idle_cyc();
    send_bit(0, 0); send_bit(1, 0);
    lit("gap_data", rd_data, 4'hD);
    lit("gap_cnt", fifo_count, 1);

    // Randomised traffic
    do_reset();
    pct = 10;
    flt_cyc = 0;
    for (int c = 0; c < 4000; c++) begin
      if (c % 250 == 0) pct = (c / 250) % 3 == 0 ? 0 : ((c / 250) % 3 == 1 ? 5 : 50);
      enable  = ($urandom_range(0, 9) != 0);
      raw_bit = $urandom_range(0, 1);
      rd_req  = ($urandom_range(0, 99) < pct);
      step();
      if (m_fault) flt_cyc++;
      if (flt_cyc > 10) begin
        flt_cyc = 0;
        do_reset();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rng_harvester.md
RNG_HARVESTER -- requirements
Module: rng_harvester

Interface
REQ-001 The module SHALL have parameter REP_LIMIT, default 32, meaning the number of consecutive identical raw samples that declares a source fault (legal range 4..255).
REQ-002 The port clk SHALL be an input, 1 bit wide, and serve as the single system clock; all state updates on its rising edge.
REQ-003 The port reset SHALL be an input, 1 bit wide, asynchronous and active-low.
REQ-004 The port raw_bit SHALL be an input, 1 bit wide, carrying the raw entropy bit, already synchronous to clk (GARO output).
REQ-005 The port enable SHALL be an input, 1 bit wide; when high, raw_bit is sampled every clk cycle.
REQ-006 The port rd_req SHALL be an input, 1 bit wide, and act as the consumer pop request.
REQ-007 The port rd_data SHALL be an output, 4 bits wide, carrying the FIFO head nibble (show-ahead).
REQ-008 The port rd_valid SHALL be an output, 1 bit wide, high when rd_data holds a valid nibble.
REQ-009 The port fifo_count SHALL be an output, 3 bits wide, giving the FIFO occupancy (0..4).
REQ-010 The port fault SHALL be an output, 1 bit wide, acting as a sticky source-health failure flag.

Function
REQ-011 The pair collector SHALL be an FSM with states IDLE and HAVE_FIRST: in IDLE with enable=1, it latches raw_bit as the first bit and moves to HAVE_FIRST; in HAVE_FIRST with enable=1, it compares raw_bit with the first bit and returns to IDLE.
REQ-012 The von Neumann rule SHALL apply to each pair: a differing pair (01 or 10) emits one debiased bit equal to the first bit; an equal pair (00 or 11) emits nothing.
REQ-013 The pair collector SHALL force the FSM to IDLE whenever enable=0, discarding any half pair; the assembler and FIFO contents are retained.
REQ-014 The assembler SHALL shift each debiased bit in MSB-first as nib <= {nib[2:0], bit}, with a 2-bit bit counter that wraps 3->0.
REQ-015 The assembler SHALL attempt a FIFO push of {nib[2:0], bit} on the same edge the 4th bit arrives, giving a latency of one cycle from the completing raw sample to rd_valid/fifo_count update.
REQ-016 The FIFO SHALL be 4 entries deep with circular 2-bit read and write pointers that wrap 3->0; rd_valid = (fifo_count != 0).
REQ-017 A pop SHALL occur when rd_req=1 and rd_valid=1; rd_req while empty is ignored with no state change.
REQ-018 On a push while full without a simultaneous pop, the new nibble SHALL be dropped; FIFO contents and count are unchanged and the assembler continues.
REQ-019 On a simultaneous push and pop, both SHALL be accepted (including when full or count=1); count is unchanged; the head advances to the next entry.
REQ-020 rd_data SHALL be 4'h0 whenever rd_valid=0.
REQ-021 The repetition counter SHALL, while enable=1, increment when raw_bit equals the previous sample, load 1 on a change, and saturate; with enable=0 it holds.
REQ-022 When the repetition counter reaches REP_LIMIT, fault SHALL set on that edge; the same edge flushes the FIFO (count=0, pointers=0), clears the assembler, and forces the FSM to IDLE.
REQ-023 While fault=1, no pushes or pops SHALL occur and rd_valid stays 0; fault is cleared only by reset.

Reset
REQ-024 Asserting reset=0 SHALL immediately, regardless of clk, force rd_data=4'h0, rd_valid=0, fifo_count=0, fault=0, FSM=IDLE, nibble and bit counter=0, repetition counter=0, previous-sample register=0, and pointers=0.
REQ-025 A reset asserted mid-pair or mid-nibble SHALL discard all partial data; the first sample after release starts a new pair.

Verification
REQ-026 With enable=1, raw_bit stream 1,0, 0,1, 1,0, 1,0 -> one nibble 4'b1011 with rd_valid=1 and fifo_count=1 one cycle after the 8th sample.
REQ-027 A stream of 1,1, 0,0, then 0,1 x4 -> equal pairs discarded; nibble 4'h0 pushed; rd_req=1 for one cycle -> fifo_count returns to 0 and rd_valid=0.
REQ-028 Fill with nibbles A,B,C,D (fifo_count=4), push E with rd_req=0 -> E dropped and head=A; then push F with rd_req=1 -> A popped, count stays 4, and the FIFO reads B,C,D,F in order.
REQ-029 With REP_LIMIT=8, raw_bit held at 1 for 8 samples while 2 nibbles are queued -> fault=1 on the 8th sample edge, fifo_count=0, rd_valid=0; further alternating input produces no pushes until reset.
REQ-030 Assert reset=0 asynchronously between clk edges while fifo_count=3 and a half pair is pending -> all outputs read 0 immediately; after release, a new 01-pair sequence assembles from bit 0.
REQ-031 Drop enable for 1 cycle between the two samples of a pair -> the half pair is discarded and the partial nibble is preserved (verify by completing the nibble afterwards).
